// File: rtl/race_pkg.sv
// race_pkg
//   Shared constants for the race controller: FSM state encoding, winner
//   codes and the saturation value of the two-digit BCD display counter.
package race_pkg;

    // FSM state encoding (also driven out on state_o for debug LEDs)
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] FINISH    = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    // winner codes
    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    // largest value the 00-99 display counter can show
    localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/race_controller_if.sv
// race_controller_if
//   Groups the race controller's input buttons, the display-counter value
//   and all race outputs.
//   master : board side (drives buttons and time_bcd, reads results)
//   slave  : race_controller
//   Signals: start, p1_btn, p2_btn, time_bcd[7:0], timer_clear, timer_tick,
//            countdown[3:0], p1_time[7:0], p2_time[7:0], winner[1:0],
//            false_start, fault_player[1:0], state_o[2:0]
interface race_controller_if;
    logic       start;
    logic       p1_btn;
    logic       p2_btn;
    logic [7:0] time_bcd;
    logic       timer_clear;
    logic       timer_tick;
    logic [3:0] countdown;
    logic [7:0] p1_time;
    logic [7:0] p2_time;
    logic [1:0] winner;
    logic       false_start;
    logic [1:0] fault_player;
    logic [2:0] state_o;

    modport master (
        output start, p1_btn, p2_btn, time_bcd,
        input  timer_clear, timer_tick, countdown, p1_time, p2_time,
               winner, false_start, fault_player, state_o
    );

    modport slave (
        input  start, p1_btn, p2_btn, time_bcd,
        output timer_clear, timer_tick, countdown, p1_time, p2_time,
               winner, false_start, fault_player, state_o
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides the system clock down to a one-cycle tick every TICK_CYCLES
//   cycles. The count is held at zero while run is low, so every
//   countdown/race starts with a full tick period.
//   Ports: clock, reset_n (sync, active low), run (count enable/clear),
//          tick (one-cycle pulse, combinational from the counter)
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = run && (cnt == TICK_CYCLES - 1);

    always_ff @(posedge clock) begin
        if (!reset_n || !run) cnt <= 32'd0;
        else if (tick)        cnt <= 32'd0;
        else                  cnt <= cnt + 32'd1;
    end

endmodule

// File: rtl/race_controller.sv
// race_controller
//   Sequences one two-player race around the 1 Hz BCD display counter:
//   IDLE -> COUNTDOWN -> RUN -> FINISH, with FAULT on a false start.
//   Generates the counter's tick/clear strobes, latches each player's
//   finish time, decides the winner and flags false starts.
//   Ports: clock, reset_n (sync, active low), bus (race_controller_if.slave)
//   All outputs except state_o are registered from next-state values so
//   they change on the same edge as the state.
module race_controller
    import race_pkg::*;
#(
    parameter int unsigned TICK_CYCLES    = 50_000_000,
    parameter int unsigned COUNTDOWN_SECS = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    race_controller_if.slave   bus
);

    logic [2:0] state, state_n;
    logic       prev_start, prev_p1, prev_p2;
    logic       start_e, p1_e, p2_e;
    logic       run, tick;
    logic       done1, done2, done1_n, done2_n;
    logic       new1, new2;
    logic [3:0] cd_n;
    logic [7:0] p1_n, p2_n;
    logic [1:0] win_n, fp_n;

    // previous-value registers reset to 1: a button held through reset
    // must not register as a press afterwards
    assign start_e = bus.start  & ~prev_start;
    assign p1_e    = bus.p1_btn & ~prev_p1;
    assign p2_e    = bus.p2_btn & ~prev_p2;

    assign run         = (state == COUNTDOWN) || (state == RUN);
    assign bus.state_o = state;

    tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_presc (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run),
        .tick    (tick)
    );

    always_comb begin
        state_n = state;
        cd_n    = bus.countdown;
        p1_n    = bus.p1_time;
        p2_n    = bus.p2_time;
        win_n   = bus.winner;
        fp_n    = bus.fault_player;
        done1_n = done1;
        done2_n = done2;
        new1    = 1'b0;
        new2    = 1'b0;
        case (state)
            IDLE: if (start_e) begin
                state_n = COUNTDOWN;
                cd_n    = 4'(COUNTDOWN_SECS);
                p1_n    = 8'h00;
                p2_n    = 8'h00;
                win_n   = W_NONE;
                fp_n    = 2'b00;
                done1_n = 1'b0;
                done2_n = 1'b0;
            end
            COUNTDOWN: begin
                // a press beats a coincident tick
                if (p1_e || p2_e) begin
                    state_n = FAULT;
                    cd_n    = 4'd0;
                    fp_n    = bus.fault_player | {p2_e, p1_e};
                end else if (tick) begin
                    if (bus.countdown == 4'd1) begin
                        state_n = RUN;
                        cd_n    = 4'd0;
                    end else begin
                        cd_n = bus.countdown - 4'd1;
                    end
                end
            end
            RUN: begin
                // abort wins over a same-cycle player press
                if (start_e) begin
                    state_n = IDLE;
                end else begin
                    new1 = p1_e & ~done1;
                    new2 = p2_e & ~done2;
                    if (new1) begin p1_n = bus.time_bcd; done1_n = 1'b1; end
                    if (new2) begin p2_n = bus.time_bcd; done2_n = 1'b1; end
                    if (!done1 && !done2) begin
                        if (new1 && new2) win_n = W_TIE;
                        else if (new1)    win_n = W_P1;
                        else if (new2)    win_n = W_P2;
                    end
                    if (done1_n && done2_n) begin
                        state_n = FINISH;
                    end else if (tick && bus.time_bcd == BCD_MAX) begin
                        // time limit: stop before the counter would wrap
                        state_n = FINISH;
                        if (!done1_n) p1_n = BCD_MAX;
                        if (!done2_n) p2_n = BCD_MAX;
                    end
                end
            end
            FINISH, FAULT: if (start_e) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            prev_start       <= 1'b1;
            prev_p1          <= 1'b1;
            prev_p2          <= 1'b1;
            done1            <= 1'b0;
            done2            <= 1'b0;
            bus.countdown    <= 4'd0;
            bus.p1_time      <= 8'h00;
            bus.p2_time      <= 8'h00;
            bus.winner       <= W_NONE;
            bus.fault_player <= 2'b00;
            bus.false_start  <= 1'b0;
            bus.timer_tick   <= 1'b0;
            bus.timer_clear  <= 1'b1;
        end else begin
            state            <= state_n;
            prev_start       <= bus.start;
            prev_p1          <= bus.p1_btn;
            prev_p2          <= bus.p2_btn;
            done1            <= done1_n;
            done2            <= done2_n;
            bus.countdown    <= cd_n;
            bus.p1_time      <= p1_n;
            bus.p2_time      <= p2_n;
            bus.winner       <= win_n;
            bus.fault_player <= fp_n;
            bus.false_start  <= (state_n == FAULT);
            // only count while the race keeps running next cycle
            bus.timer_tick   <= tick && (state == RUN) && (state_n == RUN);
            // display held at 00 outside a race, frozen in FINISH
            bus.timer_clear  <= (state_n == IDLE) || (state_n == COUNTDOWN) ||
                                (state_n == FAULT);
        end
    end

endmodule
